mul_calc_mc: RTL
================

// Module: mul_calc_mc
// PURPOSE
//   Multi-channel successor to the single-channel frame energy summer. Accepts interleaved
//   per-bin energy beats over AXI-Stream and accumulates NUM_FFT_PTS beats per channel.
//   At the end of each frame it emits the raw sum and a threshold-compressed sum on one
//   AXI-Stream master, with true backpressure. Sits between the FFT magnitude/energy stage
//   and the gain/compressor control logic.
// PARAMETERS
//   ENRGY_DATA_WIDTH  40   width of one energy beat
//   SUM_WIDTH         48   accumulator / result width (must be >= ENRGY_DATA_WIDTH)
//   NUM_FFT_PTS       16   beats per frame per channel (>= 2)
//   NUM_CH            4    channel count (>= 1); CH_W = max(1, clog2(NUM_CH))
// PORTS
//   aclk           in   1            clock, all logic on rising edge
//   aresetn        in   1            asynchronous, active-low reset
//   s_axis_tdata   in   ENRGY        energy beat
//   s_axis_tuser   in   CH_W         channel id of the beat
//   s_axis_tvalid  in   1            beat valid
//   s_axis_tready  out  1            beat accepted when valid & ready
//   cfg_thresh     in   SUM_WIDTH    compression knee T
//   cfg_shift      in   5            ratio exponent: ratio = 2^cfg_shift
//   cfg_mode       in   2            0 bypass, 1 compress, 2 limit, 3 treated as bypass
//   m_axis_tdata   out  2*SUM_WIDTH  {raw_sum, comp_sum}
//   m_axis_tuser   out  CH_W         channel id of the result
//   m_axis_tvalid  out  1            result valid
//   m_axis_tready  in   1            downstream ready
//   stat_clr       in   1            synchronous clear of the sticky flags
//   sat_flag       out  1            sticky: an accumulator saturated
//   ch_err_flag    out  1            sticky: a beat arrived with channel id >= NUM_CH
// BEHAVIOUR
//   Reset (async assert, sync release): all acc[c] = 0, cnt[c] = 0, m_axis_tvalid = 0,
//     m_axis_tdata = 0, m_axis_tuser = 0, sat_flag = 0, ch_err_flag = 0. Reset mid-frame
//     discards partial sums and any pending result.
//   s_axis_tready = ~m_axis_tvalid | m_axis_tready (combinational). No other stall source.
//   Accepted beat, channel c < NUM_CH, with cnt[c] < NUM_FFT_PTS-1:
//     acc[c] <= sat(acc[c] + data); cnt[c] <= cnt[c] + 1.
//   Accepted beat with cnt[c] == NUM_FFT_PTS-1 (frame close): S = sat(acc[c] + data);
//     acc[c] <= 0; cnt[c] <= 0; the output register loads {S, comp(S)} and tuser = c;
//     m_axis_tvalid = 1 on the next cycle (latency 1).
//   sat(x): the sum is formed at SUM_WIDTH+1 bits. On carry-out it clamps to all-ones and
//     sets sat_flag. A clamped accumulator keeps accumulating clamped.
//   comp(S) uses the cfg_* values sampled at the frame-close beat only:
//     mode 1: S <= T ? S : T + ((S - T) >> cfg_shift)
//     mode 2: S <= T ? S : T
//     mode 0/3: S
//     No divider; pure shift/compare/subtract.
//   Output register: the value holds stable while tvalid & ~tready. It clears tvalid on
//     handshake unless a new frame closes in the same cycle, in which case it reloads and
//     tvalid stays 1. This gives back-to-back results at one per cycle.
//   Channel id >= NUM_CH: the beat is accepted (tready as normal) and dropped with no state
//     change, and ch_err_flag is set.
//   Channels are independent: interleave order is arbitrary, and a partial frame on one
//     channel is unaffected by closes on others.
//   Sticky flags: stat_clr clears them. If a set event and stat_clr occur in the same cycle,
//     the set wins.
//   Output FSM: EMPTY (tvalid=0) -> FULL on close. FULL -> EMPTY on handshake without a
//     close. FULL -> FULL on close+handshake, or while stalled.
// TESTING (NUM_FFT_PTS=4, NUM_CH=2, SUM_WIDTH=48 unless noted)
//   1 ch0 beats 100,200,300,400, mode 0, ready=1 -> one result {1000,1000}, tuser=0,
//     1 cycle after the 4th beat.
//   2 ch0 four beats of 500, T=1000, shift=2, mode 1 -> {2000,1250}; mode 2 -> {2000,1000};
//     sum 800 -> {800,800}.
//   3 ch0/ch1 interleaved (ch0=10/beat, ch1=1/beat) -> ch0 {40,40} then ch1 {4,4}, in
//     close order.
//   4 m_axis_tready=0 for 5 cycles after result -> tvalid and tdata hold, s_axis_tready=0,
//     no beat lost; release -> next frame correct.
//   5 SUM_WIDTH=40, beats of 2^39 -> raw=all-ones, sat_flag=1; stat_clr -> 0; id=3 beat ->
//     dropped, ch_err_flag=1.
//   6 aresetn low after 2 ch0 beats -> all outputs 0; the next 4 beats form one fresh
//     frame with the correct sum.

Source files
------------

// File: rtl/mul_calc_mc.sv
// Multi-channel frame energy accumulator: sums NUM_FFT_PTS beats per channel and emits
// {raw_sum, compressed_sum} per closed frame on an AXI-Stream master with backpressure.
module mul_calc_mc #(
  parameter int ENRGY_DATA_WIDTH = 40,
  parameter int SUM_WIDTH        = 48,
  parameter int NUM_FFT_PTS      = 16,
  parameter int NUM_CH           = 4,
  localparam int CH_W            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [ENRGY_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [CH_W-1:0]             s_axis_tuser,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic [SUM_WIDTH-1:0]        cfg_thresh,
  input  logic [4:0]                  cfg_shift,
  input  logic [1:0]                  cfg_mode,
  output logic [2*SUM_WIDTH-1:0]      m_axis_tdata,
  output logic [CH_W-1:0]             m_axis_tuser,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  input  logic                        stat_clr,
  output logic                        sat_flag,
  output logic                        ch_err_flag
);

  localparam int CNT_W = $clog2(NUM_FFT_PTS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_FFT_PTS - 1);

  typedef enum logic {EMPTY, FULL} out_state_t;

  out_state_t            state_q, state_d;
  logic [SUM_WIDTH-1:0]  acc [NUM_CH];
  logic [CNT_W-1:0]      cnt [NUM_CH];

  logic                  accept, ch_ok, close;
  logic [SUM_WIDTH-1:0]  acc_sel, sat_sum, comp_sum, over;
  logic [CNT_W-1:0]      cnt_sel;
  logic [SUM_WIDTH:0]    sum_ext;

  assign m_axis_tvalid = (state_q == FULL);
  assign s_axis_tready = ~m_axis_tvalid | m_axis_tready;
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign ch_ok         = int'(s_axis_tuser) < NUM_CH;

  // Out-of-range ids never reach the arrays: every use below is gated by ch_ok.
  assign acc_sel = acc[s_axis_tuser];
  assign cnt_sel = cnt[s_axis_tuser];
  assign close   = accept & ch_ok & (cnt_sel == LAST_CNT);

  // One extra bit catches the carry-out; a carry clamps the sum to all-ones.
  assign sum_ext = {1'b0, acc_sel}
                 + {{(SUM_WIDTH + 1 - ENRGY_DATA_WIDTH){1'b0}}, s_axis_tdata};
  assign sat_sum = sum_ext[SUM_WIDTH] ? '1 : sum_ext[SUM_WIDTH-1:0];
  assign over    = (sat_sum - cfg_thresh) >> cfg_shift;

  always_comb begin
    // NOTE: assign a default before any branch so no path leaves the output unassigned (latch).
    comp_sum = sat_sum;
    if (sat_sum > cfg_thresh) begin
      case (cfg_mode)
        2'd1:    comp_sum = cfg_thresh + over;
        2'd2:    comp_sum = cfg_thresh;
        default: comp_sum = sat_sum;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      // NOTE: the accumulator arrays are reset explicitly; a reset must discard partial frames.
      for (int c = 0; c < NUM_CH; c++) begin
        acc[c] <= '0;
        cnt[c] <= '0;
      end
    end else if (accept && ch_ok) begin
      // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
      if (close) begin
        acc[s_axis_tuser] <= '0;
        cnt[s_axis_tuser] <= '0;
      end else begin
        acc[s_axis_tuser] <= sat_sum;
        cnt[s_axis_tuser] <= cnt_sel + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (close) state_d = FULL;
      FULL:    if (m_axis_tready && !close) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= EMPTY;
      m_axis_tdata <= '0;
      m_axis_tuser <= '0;
    end else begin
      state_q <= state_d;
      // A close can only be accepted while the register is empty or draining.
      if (close) begin
        m_axis_tdata <= {sat_sum, comp_sum};
        m_axis_tuser <= s_axis_tuser;
      end
    end
  end

  // Sticky flags: a set event in the same cycle as stat_clr wins.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sat_flag    <= 1'b0;
      ch_err_flag <= 1'b0;
    end else begin
      sat_flag    <= (accept & ch_ok & sum_ext[SUM_WIDTH]) | (sat_flag & ~stat_clr);
      ch_err_flag <= (accept & ~ch_ok) | (ch_err_flag & ~stat_clr);
    end
  end

endmodule
